// File: rtl/psram_pkg.sv
// Shared encodings and default widths for the PSRAM arbiter slice.
package psram_pkg;

    localparam int AW_DEF = 24;
    localparam int DW_DEF = 16;

    // IDLE arbitrates, WAIT holds for the controller, RESP presents the done pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_VID  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/psram_arbiter_if.sv
// Bundle of the video port, host port and PSRAM controller port around the arbiter.
//
// Handshake: each requester raises req (a level) together with stable
// addr/we/wdata and holds it until ack. ack is a one-cycle pulse meaning the
// request is taken. done is a later one-cycle pulse meaning the transaction
// finished; rdata is valid with done and held until the next done. Dropping
// req before ack withdraws the request; dropping it after ack is not allowed.
// Towards the controller, stb is a one-cycle strobe that is only issued while
// busy is low, and done from the controller is honoured only while waiting.
interface psram_arbiter_if
    import psram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          i_vid_req;
    logic [AW-1:0] i_vid_addr;
    logic          o_vid_ack;
    logic          o_vid_done;
    logic [DW-1:0] o_vid_rdata;

    logic          i_host_req;
    logic          i_host_we;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wdata;
    logic          o_host_ack;
    logic          o_host_done;
    logic [DW-1:0] o_host_rdata;

    logic          o_err_timeout;

    logic          o_psram_stb;
    logic          o_psram_we;
    logic [AW-1:0] o_psram_addr;
    logic [DW-1:0] o_psram_din;
    logic          i_psram_busy;
    logic          i_psram_done;
    logic [DW-1:0] i_psram_dout;

    // Arbiter side.
    modport slave (
        input  i_vid_req, i_vid_addr,
        output o_vid_ack, o_vid_done, o_vid_rdata,
        input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
        output o_host_ack, o_host_done, o_host_rdata,
        output o_err_timeout,
        output o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
        input  i_psram_busy, i_psram_done, i_psram_dout
    );

    // Requesters and controller side.
    modport master (
        output i_vid_req, i_vid_addr,
        input  o_vid_ack, o_vid_done, o_vid_rdata,
        output i_host_req, i_host_we, i_host_addr, i_host_wdata,
        input  o_host_ack, o_host_done, o_host_rdata,
        input  o_err_timeout,
        input  o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
        output i_psram_busy, i_psram_done, i_psram_dout
    );

endinterface

// File: rtl/psram_arb_prio.sv
// Winner select: video has priority unless it has used up its burst allowance
// while the host was waiting.
module psram_arb_prio (
    input  logic vid_req,
    input  logic host_req,
    input  logic streak_full,
    output logic win_vid,
    output logic win_host
);

    assign win_host = host_req && (!vid_req || streak_full);
    assign win_vid  = vid_req && !win_host;

endmodule

// File: rtl/psram_arbiter.sv
// Two-requester arbiter in front of the single PSRAM controller port.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int MAX_VID_BURST = 8,
    parameter int TIMEOUT       = 1023,
    parameter int TW            = 10
) (
    input  logic clk_100mhz,
    input  logic rstn_i,
    psram_arbiter_if.slave bus,
    output state_t dbg_state
);

    localparam int SW = $clog2(MAX_VID_BURST + 1);

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [SW-1:0] vid_streak_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          streak_full;
    logic          win_vid, win_host;
    logic          grant_vid, grant_host, end_ok, end_tmo;

    logic          stb_q, we_q, vid_ack_q, host_ack_q, vid_done_q, host_done_q, err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q, vid_rdata_q, host_rdata_q;

    assign streak_full = (vid_streak_q >= SW'(MAX_VID_BURST));

    psram_arb_prio u_prio (
        .vid_req     (bus.i_vid_req),
        .host_req    (bus.i_host_req),
        .streak_full (streak_full),
        .win_vid     (win_vid),
        .win_host    (win_host)
    );

    // State register.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state plus the grant/finish strobes that steer the datapath.
    always_comb begin
        state_d    = state_q;
        grant_vid  = 1'b0;
        grant_host = 1'b0;
        end_ok     = 1'b0;
        end_tmo    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.i_psram_busy) begin
                    if (win_host) begin
                        grant_host = 1'b1;
                        state_d    = WAIT;
                    end else if (win_vid) begin
                        grant_vid = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.i_psram_done) begin
                    end_ok  = 1'b1;
                    state_d = RESP;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    end_tmo = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter runs only while waiting on the controller.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i)               tmo_cnt_q <= '0;
        else if (state_q == WAIT)  tmo_cnt_q <= tmo_cnt_q + TW'(1);
        else                       tmo_cnt_q <= '0;
    end

    // Video streak: counts video grants the host had to sit through.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            vid_streak_q <= '0;
        end else if (grant_host) begin
            vid_streak_q <= '0;
        end else if (grant_vid && bus.i_host_req) begin
            if (!streak_full) vid_streak_q <= vid_streak_q + SW'(1);
        end else if (state_q == IDLE && !bus.i_host_req) begin
            vid_streak_q <= '0;
        end
    end

    // Registered controller command, acks, done pulses and read data.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q      <= OWN_VID;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            vid_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            vid_done_q   <= 1'b0;
            host_done_q  <= 1'b0;
            err_q        <= 1'b0;
            vid_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            stb_q       <= 1'b0;
            vid_ack_q   <= 1'b0;
            host_ack_q  <= 1'b0;
            vid_done_q  <= 1'b0;
            host_done_q <= 1'b0;
            err_q       <= 1'b0;
            if (grant_vid) begin
                owner_q   <= OWN_VID;
                stb_q     <= 1'b1;
                vid_ack_q <= 1'b1;
                we_q      <= 1'b0;
                addr_q    <= bus.i_vid_addr;
                din_q     <= '0;
            end else if (grant_host) begin
                owner_q    <= OWN_HOST;
                stb_q      <= 1'b1;
                host_ack_q <= 1'b1;
                we_q       <= bus.i_host_we;
                addr_q     <= bus.i_host_addr;
                din_q      <= bus.i_host_wdata;
            end
            if (end_ok || end_tmo) begin
                err_q <= end_tmo;
                if (owner_q == OWN_VID) begin
                    vid_done_q  <= 1'b1;
                    vid_rdata_q <= end_ok ? bus.i_psram_dout : '0;
                end else begin
                    host_done_q  <= 1'b1;
                    host_rdata_q <= end_ok ? bus.i_psram_dout : '0;
                end
            end
        end
    end

    assign bus.o_psram_stb   = stb_q;
    assign bus.o_psram_we    = we_q;
    assign bus.o_psram_addr  = addr_q;
    assign bus.o_psram_din   = din_q;
    assign bus.o_vid_ack     = vid_ack_q;
    assign bus.o_vid_done    = vid_done_q;
    assign bus.o_vid_rdata   = vid_rdata_q;
    assign bus.o_host_ack    = host_ack_q;
    assign bus.o_host_done   = host_done_q;
    assign bus.o_host_rdata  = host_rdata_q;
    assign bus.o_err_timeout = err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: vector table plus hand-written corner sequences.
module tb_psram_arbiter;
    import psram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic   clk_100mhz = 1'b0;
    logic   rstn_i     = 1'b0;
    state_t dbg_state;

    always #5 clk_100mhz = ~clk_100mhz;

    psram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    psram_arbiter #(
        .AW(AW), .DW(DW), .MAX_VID_BURST(8), .TIMEOUT(1023), .TW(10)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rstn_i     (rstn_i),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    typedef struct {
        logic          vid_req;
        logic          host_req;
        logic          host_we;
        logic [AW-1:0] vid_addr;
        logic [AW-1:0] host_addr;
        logic [DW-1:0] host_wdata;
        int            lat;
        logic [DW-1:0] dout;
        logic          exp_vid;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
    } vec_t;

    vec_t          vecs[7];
    int            checks   = 0;
    int            failures = 0;
    logic [1:0]    exp_q[$];
    logic [DW-1:0] exp_vid_rdata  = '0;
    logic [DW-1:0] exp_host_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic drop_reqs();
        bus.i_vid_req  = 1'b0;
        bus.i_host_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.i_vid_req    = v.vid_req;
        bus.i_vid_addr   = v.vid_addr;
        bus.i_host_req   = v.host_req;
        bus.i_host_we    = v.host_we;
        bus.i_host_addr  = v.host_addr;
        bus.i_host_wdata = v.host_wdata;
        step();
        check("grant_stb",  32'(bus.o_psram_stb), 32'd1);
        check("vid_ack",    32'(bus.o_vid_ack), 32'(v.exp_vid));
        check("host_ack",   32'(bus.o_host_ack), 32'(!v.exp_vid));
        check("psram_we",   32'(bus.o_psram_we), 32'(v.exp_we));
        check("psram_addr", 32'(bus.o_psram_addr), 32'(v.exp_addr));
        check("psram_din",  32'(bus.o_psram_din), 32'(v.exp_din));
        drop_reqs();
        step();
        check("stb_ack_one_cycle", 32'({bus.o_psram_stb, bus.o_vid_ack, bus.o_host_ack}), 32'd0);
        repeat (v.lat - 1) step();
        check("no_early_done", 32'({bus.o_vid_done, bus.o_host_done}), 32'd0);
        bus.i_psram_done = 1'b1;
        bus.i_psram_dout = v.dout;
        step();
        bus.i_psram_done = 1'b0;
        bus.i_psram_dout = 16'h5A5A;
        if (v.exp_vid) exp_vid_rdata = v.dout;
        else           exp_host_rdata = v.dout;
        check("vid_done",   32'(bus.o_vid_done), 32'(v.exp_vid));
        check("host_done",  32'(bus.o_host_done), 32'(!v.exp_vid));
        check("vid_rdata",  32'(bus.o_vid_rdata), 32'(exp_vid_rdata));
        check("host_rdata", 32'(bus.o_host_rdata), 32'(exp_host_rdata));
        check("no_err",     32'(bus.o_err_timeout), 32'd0);
        step();
        check("done_one_cycle", 32'({bus.o_vid_done, bus.o_host_done}), 32'd0);
        check("back_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int  n;
        int  cnt;
        logic got;

        // vid_req host_req we vid_addr host_addr wdata lat dout | exp_vid exp_we exp_addr exp_din
        vecs[0] = '{1'b0, 1'b1, 1'b1, 24'h000000, 24'h000123, 16'hABCD, 5, 16'h0000,
                    1'b0, 1'b1, 24'h000123, 16'hABCD};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 24'h001000, 24'h000000, 16'h0000, 3, 16'h0F0F,
                    1'b1, 1'b0, 24'h001000, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h00FFFF, 16'h9999, 2, 16'h1234,
                    1'b0, 1'b0, 24'h00FFFF, 16'h9999};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 24'h00ABCD, 24'h000777, 16'h1111, 4, 16'h5555,
                    1'b1, 1'b0, 24'h00ABCD, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'hFFFFFF, 16'h0000, 2, 16'hFFFF,
                    1'b0, 1'b0, 24'hFFFFFF, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 16'h0000, 6, 16'h8001,
                    1'b1, 1'b0, 24'h000000, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 24'h000042, 24'h000000, 16'h0000, 2, 16'h7777,
                    1'b1, 1'b0, 24'h000042, 16'h0000};

        bus.i_vid_req    = 1'b0;
        bus.i_vid_addr   = '0;
        bus.i_host_req   = 1'b0;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = '0;
        bus.i_host_wdata = '0;
        bus.i_psram_busy = 1'b0;
        bus.i_psram_done = 1'b0;
        bus.i_psram_dout = '0;

        // Reset values.
        repeat (3) @(posedge clk_100mhz);
        #1;
        check("rst_outputs", 32'({bus.o_psram_stb, bus.o_psram_we, bus.o_vid_ack, bus.o_vid_done,
                                  bus.o_host_ack, bus.o_host_done, bus.o_err_timeout}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rstn_i = 1'b1;
        step();

        // Table of single transactions.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both ports requesting continuously: 8 video grants, then host, repeating.
        bus.i_vid_addr  = 24'h002000;
        bus.i_host_addr = 24'h003000;
        bus.i_host_we   = 1'b0;
        bus.i_vid_req   = 1'b1;
        bus.i_host_req  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            repeat (8) exp_q.push_back(2'd1);
            exp_q.push_back(2'd0);
        end
        for (int g = 0; g < 27; g++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                step();
                if (bus.o_psram_stb) got = 1'b1;
            end
            check("burst_stb", 32'(got), 32'd1);
            if (!got) break;
            check("burst_grant", bus.o_vid_ack ? 32'd1 : (bus.o_host_ack ? 32'd0 : 32'd2),
                  32'(exp_q.pop_front()));
            bus.i_psram_done = 1'b1;
            bus.i_psram_dout = 16'h0101;
            step();
            bus.i_psram_done = 1'b0;
        end
        check("burst_queue_empty", 32'(exp_q.size()), 32'd0);
        drop_reqs();
        step();
        step();

        // Controller busy blocks any grant; grant follows the cycle busy falls.
        bus.i_psram_busy = 1'b1;
        bus.i_host_req   = 1'b1;
        bus.i_host_we    = 1'b1;
        bus.i_host_addr  = 24'h000456;
        bus.i_host_wdata = 16'h2222;
        cnt = 0;
        repeat (20) begin
            step();
            if (bus.o_psram_stb || bus.o_vid_ack || bus.o_host_ack) cnt++;
        end
        check("busy_no_grant", 32'(cnt), 32'd0);
        bus.i_psram_busy = 1'b0;
        step();
        check("busy_release_ack", 32'(bus.o_host_ack), 32'd1);
        check("busy_release_stb", 32'(bus.o_psram_stb), 32'd1);
        drop_reqs();
        bus.i_psram_done = 1'b1;
        bus.i_psram_dout = 16'h0000;
        step();
        bus.i_psram_done = 1'b0;
        check("busy_host_done", 32'(bus.o_host_done), 32'd1);
        step();

        // Controller never answers: timeout 1023 cycles after stb.
        bus.i_psram_dout = 16'hBEEF;
        bus.i_host_req   = 1'b1;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = 24'h000200;
        step();
        check("tmo_ack", 32'(bus.o_host_ack), 32'd1);
        drop_reqs();
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 1100 && !got; i++) begin
            step();
            n++;
            if (bus.o_err_timeout) got = 1'b1;
        end
        check("tmo_seen", 32'(got), 32'd1);
        check("tmo_cycles", 32'(n), 32'd1023);
        check("tmo_host_done", 32'(bus.o_host_done), 32'd1);
        check("tmo_host_rdata", 32'(bus.o_host_rdata), 32'd0);
        check("tmo_vid_done", 32'(bus.o_vid_done), 32'd0);
        exp_host_rdata = '0;
        step();
        check("tmo_err_one_cycle", 32'(bus.o_err_timeout), 32'd0);
        check("tmo_idle", 32'(dbg_state), 32'(IDLE));
        run_vec(vecs[6]);

        // Reset during WAIT drops the transaction silently.
        bus.i_vid_req  = 1'b1;
        bus.i_vid_addr = 24'h000099;
        step();
        check("rst_wait_ack", 32'(bus.o_vid_ack), 32'd1);
        drop_reqs();
        step();
        step();
        check("rst_wait_state", 32'(dbg_state), 32'(WAIT));
        rstn_i = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({bus.o_psram_stb, bus.o_psram_we, bus.o_vid_ack, bus.o_vid_done,
                                     bus.o_host_ack, bus.o_host_done, bus.o_err_timeout}), 32'd0);
        check("rst_async_addr", 32'(bus.o_psram_addr), 32'd0);
        check("rst_async_rdata", 32'({bus.o_vid_rdata, bus.o_host_rdata}), 32'd0);
        check("rst_async_state", 32'(dbg_state), 32'(IDLE));
        step();
        step();
        rstn_i = 1'b1;
        step();
        bus.i_psram_done = 1'b1;
        bus.i_psram_dout = 16'h3333;
        step();
        bus.i_psram_done = 1'b0;
        check("late_done_ignored", 32'({bus.o_vid_done, bus.o_host_done, bus.o_err_timeout,
                                        bus.o_psram_stb}), 32'd0);
        check("late_done_rdata", 32'(bus.o_vid_rdata), 32'd0);
        check("late_done_state", 32'(dbg_state), 32'(IDLE));
        step();
        check("late_done_quiet", 32'({bus.o_vid_done, bus.o_host_done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
